dff_response_checker: RTL and testbench

//  Synthesizable response checker: observing end of the set/reset D-flip-flop interface driven by the test stimulus.

---
 rtl/dff_response_checker.sv | 162 ++++++++++++++++
 tb/tb_dff_response_checker.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dff_response_checker.sv
// Response checker for a set/reset D flip-flop: runs a golden flop model beside the DUT and counts miscompares.
// Optional first-failure snapshot (ff_cycle/ff_vec) is built only when DFF_CHK_SNAPSHOT_EN is defined.
module dff_response_checker #(
   parameter int CNT_W       = 8,
   parameter int CHK_W       = 16,
   parameter bit RESET_WINS  = 1'b1,
   parameter bit STOP_ON_ERR = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             obs_reset,
   input  logic             obs_set,
   input  logic             obs_d,
   input  logic             obs_q,
   output logic             exp_q,
   output logic             mismatch,
   output logic             err_sticky,
   output logic [CNT_W-1:0] err_count,
   output logic [CHK_W-1:0] chk_count,
   output logic [1:0]       state,
   output logic [CHK_W-1:0] ff_cycle,
   output logic [3:0]       ff_vec
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SYNC  = 2'b01,
      CHECK = 2'b10,
      HALT  = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic             model_q, model_d;
   logic             mismatch_q, mismatch_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CHK_W-1:0] chk_cnt_q, chk_cnt_d;

   // Golden flop model runs in every state so it is already valid on entry to CHECK.
   always_comb begin
      model_d = obs_d;
      if (obs_reset && obs_set) begin
         model_d = RESET_WINS ? 1'b0 : 1'b1;
      end else if (obs_reset) begin
         model_d = 1'b0;
      end else if (obs_set) begin
         model_d = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      mismatch_d = 1'b0;
      sticky_d   = sticky_q;
      err_cnt_d  = err_cnt_q;
      chk_cnt_d  = chk_cnt_q;
      case (state_q)
         IDLE: begin
            if (en) begin
               state_d   = SYNC;
               sticky_d  = 1'b0;
               err_cnt_d = '0;
               chk_cnt_d = '0;
            end
         end
         SYNC: begin
            if (!en) begin
               state_d = IDLE;
            end else if (obs_reset || obs_set) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (!en) begin
               state_d = IDLE;
            end else begin
               // Counters saturate at all-ones instead of wrapping.
               if (chk_cnt_q != '1) begin
                  chk_cnt_d = chk_cnt_q + CHK_W'(1);
               end
               if (obs_q != model_q) begin
                  mismatch_d = 1'b1;
                  sticky_d   = 1'b1;
                  if (err_cnt_q != '1) begin
                     err_cnt_d = err_cnt_q + CNT_W'(1);
                  end
                  if (STOP_ON_ERR) begin
                     state_d = HALT;
                  end
               end
            end
         end
         HALT: begin
            if (!en) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         model_q    <= 1'b0;
         mismatch_q <= 1'b0;
         sticky_q   <= 1'b0;
         err_cnt_q  <= '0;
         chk_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         model_q    <= model_d;
         mismatch_q <= mismatch_d;
         sticky_q   <= sticky_d;
         err_cnt_q  <= err_cnt_d;
         chk_cnt_q  <= chk_cnt_d;
      end
   end

   assign exp_q      = model_q;
   assign mismatch   = mismatch_q;
   assign err_sticky = sticky_q;
   assign err_count  = err_cnt_q;
   assign chk_count  = chk_cnt_q;
   assign state      = state_q;

`ifdef DFF_CHK_SNAPSHOT_EN
   logic [CHK_W-1:0] ff_cycle_q, ff_cycle_d;
   logic [3:0]       ff_vec_q, ff_vec_d;

   // ff_cycle holds the compare count before the failing compare is added.
   always_comb begin
      ff_cycle_d = ff_cycle_q;
      ff_vec_d   = ff_vec_q;
      if (state_q == IDLE && en) begin
         ff_cycle_d = '0;
         ff_vec_d   = '0;
      end else if (state_q == CHECK && en && (obs_q != model_q) && !sticky_q) begin
         ff_cycle_d = chk_cnt_q;
         ff_vec_d   = {obs_reset, obs_set, obs_d, obs_q};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ff_cycle_q <= '0;
         ff_vec_q   <= '0;
      end else begin
         ff_cycle_q <= ff_cycle_d;
         ff_vec_q   <= ff_vec_d;
      end
   end

   assign ff_cycle = ff_cycle_q;
   assign ff_vec   = ff_vec_q;
`else
   assign ff_cycle = '0;
   assign ff_vec   = '0;
`endif

endmodule

// File: tb/tb_dff_response_checker.sv
// Directed bench for dff_response_checker: a behavioural flop plays the DUT, obs_q can be corrupted on demand.
// Four checker instances share the stimulus: default, STOP_ON_ERR=1, CNT_W=2, RESET_WINS=0.
module tb_dff_response_checker;

   logic clk = 1'b0;
   logic reset, en, obs_reset, obs_set, obs_d, flip, dut_q, obs_q;

   logic        exp0, mm0, st0;
   logic [7:0]  err0;
   logic [15:0] chk0, ffc0;
   logic [1:0]  state0;
   logic [3:0]  ffv0;

   logic        exp1, mm1, st1;
   logic [7:0]  err1;
   logic [15:0] chk1, ffc1;
   logic [1:0]  state1;
   logic [3:0]  ffv1;

   logic        exp2, mm2, st2;
   logic [1:0]  err2;
   logic [15:0] chk2, ffc2;
   logic [1:0]  state2;
   logic [3:0]  ffv2;

   logic        exp3, mm3, st3;
   logic [7:0]  err3;
   logic [15:0] chk3, ffc3;
   logic [1:0]  state3;
   logic [3:0]  ffv3;

   int testCount = 0;
   int failCount = 0;

   always #5 clk = ~clk;

   // Stand-in DUT: reset-dominant set/reset flop; flip corrupts its observed output.
   always @(posedge clk) begin
      dut_q <= obs_reset ? 1'b0 : (obs_set ? 1'b1 : obs_d);
   end
   assign obs_q = dut_q ^ flip;

   dff_response_checker u0 (
      .clk(clk), .reset(reset), .en(en), .obs_reset(obs_reset), .obs_set(obs_set), .obs_d(obs_d),
      .obs_q(obs_q), .exp_q(exp0), .mismatch(mm0), .err_sticky(st0), .err_count(err0),
      .chk_count(chk0), .state(state0), .ff_cycle(ffc0), .ff_vec(ffv0));

   dff_response_checker #(.STOP_ON_ERR(1'b1)) u1 (
      .clk(clk), .reset(reset), .en(en), .obs_reset(obs_reset), .obs_set(obs_set), .obs_d(obs_d),
      .obs_q(obs_q), .exp_q(exp1), .mismatch(mm1), .err_sticky(st1), .err_count(err1),
      .chk_count(chk1), .state(state1), .ff_cycle(ffc1), .ff_vec(ffv1));

   dff_response_checker #(.CNT_W(2)) u2 (
      .clk(clk), .reset(reset), .en(en), .obs_reset(obs_reset), .obs_set(obs_set), .obs_d(obs_d),
      .obs_q(obs_q), .exp_q(exp2), .mismatch(mm2), .err_sticky(st2), .err_count(err2),
      .chk_count(chk2), .state(state2), .ff_cycle(ffc2), .ff_vec(ffv2));

   dff_response_checker #(.RESET_WINS(1'b0)) u3 (
      .clk(clk), .reset(reset), .en(en), .obs_reset(obs_reset), .obs_set(obs_set), .obs_d(obs_d),
      .obs_q(obs_q), .exp_q(exp3), .mismatch(mm3), .err_sticky(st3), .err_count(err3),
      .chk_count(chk3), .state(state3), .ff_cycle(ffc3), .ff_vec(ffv3));

   // Drive one cycle of inputs, then settle just past the rising edge before checking.
   task applyStimulus(input logic rst_i, input logic en_i, input logic r_i, input logic s_i,
                      input logic d_i, input logic flip_i);
      reset     = rst_i;
      en        = en_i;
      obs_reset = r_i;
      obs_set   = s_i;
      obs_d     = d_i;
      flip      = flip_i;
      @(posedge clk);
      #1;
   endtask

   task checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   initial begin
      logic [3:0] pat;
      pat = 4'b0101;

      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("rst_state", 32'(state0), 0);
      checkOutput("rst_exp", 32'(exp0), 0);
      checkOutput("rst_sticky", 32'(st0), 0);
      checkOutput("rst_err", 32'(err0), 0);
      checkOutput("rst_chk", 32'(chk0), 0);
      checkOutput("rst_mm", 32'(mm0), 0);
      checkOutput("rst_ffc", 32'(ffc0), 0);
      checkOutput("rst_ffv", 32'(ffv0), 0);
      checkOutput("rst_state_u1", 32'(state1), 0);

      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("idle_to_sync", 32'(state0), 1);

      applyStimulus(0, 1, 1, 1, 0, 0);
      checkOutput("sync_to_check", 32'(state0), 2);
      checkOutput("both_reset_wins", 32'(exp0), 0);
      checkOutput("both_set_wins", 32'(exp3), 1);
      checkOutput("sync_to_check_u3", 32'(state3), 2);

      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1, 0, 0, pat[i], 0);
         checkOutput("good_mm", 32'(mm0), 0);
      end
      checkOutput("good_chk", 32'(chk0), 4);
      checkOutput("good_err", 32'(err0), 0);
      checkOutput("good_exp", 32'(exp0), 0);
      checkOutput("good_sticky", 32'(st0), 0);

      applyStimulus(0, 1, 0, 0, 0, 1);
      checkOutput("bad_mm", 32'(mm0), 1);
      checkOutput("bad_sticky", 32'(st0), 1);
      checkOutput("bad_err", 32'(err0), 1);
      checkOutput("bad_chk", 32'(chk0), 5);
      checkOutput("halt_state", 32'(state1), 3);
      checkOutput("halt_err", 32'(err1), 1);
      checkOutput("halt_chk", 32'(chk1), 5);
      checkOutput("sat_err_first", 32'(err2), 1);

      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("pulse_end", 32'(mm0), 0);
      checkOutput("after_chk", 32'(chk0), 6);
      checkOutput("after_sticky", 32'(st0), 1);
      checkOutput("halt_hold_chk", 32'(chk1), 5);
      checkOutput("halt_mm", 32'(mm1), 0);

      repeat (5) applyStimulus(0, 1, 0, 0, 0, 1);
      checkOutput("sat_err", 32'(err2), 3);
      checkOutput("sat_sticky", 32'(st2), 1);
      checkOutput("multi_err", 32'(err0), 6);
      checkOutput("multi_chk", 32'(chk0), 11);
      checkOutput("multi_mm", 32'(mm0), 1);
      checkOutput("halt_frozen_err", 32'(err1), 1);
      checkOutput("halt_frozen_chk", 32'(chk1), 5);

      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("en_off_state", 32'(state0), 0);
      checkOutput("en_off_mm", 32'(mm0), 0);
      checkOutput("en_off_err", 32'(err0), 6);
      checkOutput("en_off_chk", 32'(chk0), 11);
      checkOutput("halt_to_idle", 32'(state1), 0);

      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("resync_state", 32'(state0), 1);
      checkOutput("resync_err", 32'(err0), 0);
      checkOutput("resync_chk", 32'(chk0), 0);
      checkOutput("resync_sticky", 32'(st0), 0);
      checkOutput("resync_err_u1", 32'(err1), 0);
      checkOutput("resync_state_u1", 32'(state1), 1);
      checkOutput("resync_err_u2", 32'(err2), 0);

      for (int i = 0; i < 20; i++) begin
         applyStimulus(0, 1, 0, 0, i[0], 0);
      end
      checkOutput("no_pulse_state", 32'(state0), 1);
      checkOutput("no_pulse_chk", 32'(chk0), 0);
      checkOutput("no_pulse_exp", 32'(exp0), 1);

      applyStimulus(0, 1, 0, 1, 0, 0);
      checkOutput("set_sync_state", 32'(state0), 2);
      checkOutput("set_exp", 32'(exp0), 1);
      applyStimulus(0, 1, 0, 0, 1, 0);
      applyStimulus(0, 1, 1, 0, 1, 0);
      checkOutput("dut_reset_exp", 32'(exp0), 0);
      applyStimulus(0, 1, 0, 0, 1, 0);
      checkOutput("track_chk", 32'(chk0), 3);
      checkOutput("track_err", 32'(err0), 0);
      checkOutput("track_exp", 32'(exp0), 1);
      checkOutput("track_mm", 32'(mm0), 0);

      applyStimulus(1, 1, 0, 0, 1, 0);
      checkOutput("midrun_rst_state", 32'(state0), 0);
      checkOutput("midrun_rst_chk", 32'(chk0), 0);
      checkOutput("midrun_rst_exp", 32'(exp0), 0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
